// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions.
// Holds the datapath width, the special instruction encodings, the fetch FSM
// state type and the PC increment used by the fetch stage.
package mips_pkg;

  localparam int unsigned LEN       = 32;
  localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;
  localparam logic [31:0] NOP_WORD  = 32'h0000_0000;
  localparam int unsigned PC_INC    = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/instruction_memory.sv
// Word-addressed RAM with one synchronous write port and one asynchronous
// read port. Used as the fetch-stage instruction memory and usable for
// data-memory debug loading.
//   i_clk    : write clock
//   i_we     : write strobe, write completes on the next posedge
//   i_waddr  : write word address
//   i_wdata  : write word
//   i_raddr  : read word address
//   o_rdata  : combinational read data
// Contents are not reset.
module instruction_memory #(
  parameter int unsigned LEN         = 32,
  parameter int unsigned RAM_DEPTH   = 256,
  parameter int unsigned NB_RAM_ADDR = $clog2(RAM_DEPTH)
) (
  input  logic                   i_clk,
  input  logic                   i_we,
  input  logic [NB_RAM_ADDR-1:0] i_waddr,
  input  logic [LEN-1:0]         i_wdata,
  input  logic [NB_RAM_ADDR-1:0] i_raddr,
  output logic [LEN-1:0]         o_rdata
);

  logic [LEN-1:0] mem [RAM_DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = mem[i_raddr];

endmodule

// File: rtl/tl_instruction_fetch.sv
// MIPS fetch stage: PC register, instruction memory and IF/ID register.
// Ports:
//   i_clk, i_rst (async, active-low)
//   i_enable        : run request; low returns to IDLE where loading is allowed
//   i_stall         : hold PC and IF/ID
//   i_jump / i_jump_target       : jump redirect (wins over branch)
//   i_branch_taken / i_branch_target : branch redirect
//   i_load_we / i_load_addr / i_load_data : instruction load port (IDLE only)
//   o_instruccion / o_adder_pc   : IF/ID instruction and PC+4
//   o_pc            : current PC
//   o_valid         : IF/ID holds a real instruction
//   o_halt          : halt word fetched, sticky until IDLE
// Build option: MIPS_DELAY_SLOT_EN -- when defined a redirect loads the
// sequential (delay slot) instruction into IF/ID instead of a bubble.
module tl_instruction_fetch
  import mips_pkg::*;
#(
  parameter int unsigned    LEN         = mips_pkg::LEN,
  parameter int unsigned    RAM_DEPTH   = 256,
  parameter int unsigned    NB_RAM_ADDR = $clog2(RAM_DEPTH),
  parameter logic [LEN-1:0] HALT_WORD   = mips_pkg::HALT_WORD,
  parameter logic [LEN-1:0] NOP_WORD    = mips_pkg::NOP_WORD
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_enable,
  input  logic                   i_stall,
  input  logic                   i_jump,
  input  logic [LEN-1:0]         i_jump_target,
  input  logic                   i_branch_taken,
  input  logic [LEN-1:0]         i_branch_target,
  input  logic                   i_load_we,
  input  logic [NB_RAM_ADDR-1:0] i_load_addr,
  input  logic [LEN-1:0]         i_load_data,
  output logic [LEN-1:0]         o_instruccion,
  output logic [LEN-1:0]         o_adder_pc,
  output logic [LEN-1:0]         o_pc,
  output logic                   o_valid,
  output logic                   o_halt
);

  fetch_state_t   state;
  logic [LEN-1:0] pc;
  logic [LEN-1:0] pc_plus4;
  logic [LEN-1:0] fetch_word;
  logic [LEN-1:0] redirect_target;
  logic           redirect;
  logic           mem_we;

  assign mem_we          = i_load_we && (state == IDLE);
  assign pc_plus4        = pc + LEN'(PC_INC);
  assign redirect        = i_jump || i_branch_taken;
  assign redirect_target = i_jump ? i_jump_target : i_branch_target;

  // PC bits [1:0] are dropped; bits above the index wrap the address.
  instruction_memory #(
    .LEN         (LEN),
    .RAM_DEPTH   (RAM_DEPTH),
    .NB_RAM_ADDR (NB_RAM_ADDR)
  ) u_imem (
    .i_clk   (i_clk),
    .i_we    (mem_we),
    .i_waddr (i_load_addr),
    .i_wdata (i_load_data),
    .i_raddr (pc[NB_RAM_ADDR+1:2]),
    .o_rdata (fetch_word)
  );

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state         <= IDLE;
      pc            <= '0;
      o_instruccion <= NOP_WORD;
      o_adder_pc    <= '0;
      o_valid       <= 1'b0;
      o_halt        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          pc            <= '0;
          o_instruccion <= NOP_WORD;
          o_adder_pc    <= '0;
          o_valid       <= 1'b0;
          o_halt        <= 1'b0;
          if (i_enable) begin
            state <= RUN;
          end
        end

        RUN: begin
          if (!i_enable) begin
            state         <= IDLE;
            pc            <= '0;
            o_instruccion <= NOP_WORD;
            o_adder_pc    <= '0;
            o_valid       <= 1'b0;
            o_halt        <= 1'b0;
          end else if (redirect) begin
            // Redirect overrides stall.
            pc <= redirect_target;
`ifdef MIPS_DELAY_SLOT_EN
            o_instruccion <= fetch_word;
            o_adder_pc    <= pc_plus4;
            o_valid       <= 1'b1;
`else
            o_instruccion <= NOP_WORD;
            o_adder_pc    <= '0;
            o_valid       <= 1'b0;
`endif
          end else if (!i_stall) begin
            o_instruccion <= fetch_word;
            o_adder_pc    <= pc_plus4;
            o_valid       <= 1'b1;
            if (fetch_word == HALT_WORD) begin
              // PC parks on the halt word address.
              o_halt <= 1'b1;
              state  <= HALTED;
            end else begin
              pc <= pc_plus4;
            end
          end
        end

        HALTED: begin
          if (!i_enable) begin
            state         <= IDLE;
            pc            <= '0;
            o_instruccion <= NOP_WORD;
            o_adder_pc    <= '0;
            o_valid       <= 1'b0;
            o_halt        <= 1'b0;
          end else if (!i_stall) begin
            // Halt word leaves IF/ID once; bubbles follow.
            o_instruccion <= NOP_WORD;
            o_adder_pc    <= '0;
            o_valid       <= 1'b0;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign o_pc = pc;

endmodule

// File: doc/tl_instruction_fetch.md
Name: tl_instruction_fetch

Overview:
- Fetch stage of the MIPS pipeline. Produces the instruction and PC+4 consumed by tl_instruction_decode.
- Owns the PC register, a word-addressed instruction memory with a debug load port, and the IF/ID pipeline register.
- Handles stall, jump/branch redirect, and halt detection.
- State updates on posedge i_clk, so the IF/ID register is stable when decode samples it on negedge.

Parameters:
- LEN, 32, data/instruction/PC width
- RAM_DEPTH, 256, instruction memory depth in words
- NB_RAM_ADDR, $clog2(RAM_DEPTH), memory word-address width
- HALT_WORD, 32'hFFFF_FFFF, instruction encoding that stops fetch
- NOP_WORD, 32'h0000_0000, bubble inserted on squash/idle

Ports:
- i_clk  in  1  clock
- i_rst  in  1  asynchronous reset, active-low
- i_enable  in  1  run request from debug unit; low = IDLE (load allowed)
- i_stall  in  1  hazard unit: hold PC and IF/ID
- i_jump  in  1  jump redirect valid
- i_jump_target  in  LEN  jump byte address
- i_branch_taken  in  1  branch redirect valid
- i_branch_target  in  LEN  branch byte address
- i_load_we  in  1  instruction memory write strobe
- i_load_addr  in  NB_RAM_ADDR  word address to write
- i_load_data  in  LEN  word to write
- o_instruccion  out  LEN  IF/ID instruction
- o_adder_pc  out  LEN  IF/ID PC+4
- o_pc  out  LEN  current PC (debug)
- o_valid  out  1  IF/ID holds a real instruction
- o_halt  out  1  halt word has been fetched; sticky until IDLE

Behaviour:
- Reset (async, i_rst=0):
  - state=IDLE; PC=0.
  - o_instruccion=NOP_WORD, o_adder_pc=0, o_valid=0, o_halt=0.
  - Memory contents are not reset.
- Memory:
  - Combinational read at PC[NB_RAM_ADDR+1:2]; PC bits [1:0] are ignored.
  - PC above 4*RAM_DEPTH wraps via the low index bits.
- State IDLE:
  - Writes with i_load_we=1 complete on the next edge.
  - PC held at 0; IF/ID = NOP, o_valid=0.
  - i_enable=1 -> RUN.
- State RUN:
  - Load writes are ignored.
  - Per-edge priority: redirect > stall > sequential.
  - Jump: i_jump=1 -> PC=i_jump_target. i_jump wins if i_branch_taken is also 1.
  - Branch: i_branch_taken=1 -> PC=i_branch_target.
  - Redirect effect on IF/ID: squash to NOP, o_valid=0 (see optional feature). A redirect during i_stall still redirects.
  - Stall (no redirect): PC and IF/ID hold.
  - Sequential: PC=PC+4, modulo 2^LEN; 32'hFFFF_FFFC wraps to 0. IF/ID = {mem[PC], PC+4}, o_valid=1.
  - Halt: on a sequential fetch of HALT_WORD:
    - IF/ID takes it with o_valid=1; o_halt=1 on the same edge.
    - PC stays at the halt word address; state -> HALTED.
  - i_enable=0 -> IDLE. PC=0, IF/ID cleared.
- State HALTED:
  - PC frozen.
  - Once IF/ID is not stalled, it loads NOP with o_valid=0, so the halt word is delivered exactly once.
  - Redirects are ignored. o_halt stays 1.
  - i_enable=0 -> IDLE; clears o_halt, PC=0.
- Reset mid-run: immediate return to reset values. Loaded program is kept.
- Latency: instruction at address A is visible on o_instruccion one posedge after PC=A.

Optional Feature:
- Macro: MIPS_DELAY_SLOT_EN.
- Defined: a redirect does not squash. IF/ID loads the sequential instruction (delay slot) with o_valid=1, and PC takes the target.
- Undefined: a redirect loads NOP into IF/ID with o_valid=0.

Decomposition:
- Shared package mips_pkg:
  - LEN, HALT_WORD, NOP_WORD
  - fetch state enum {IDLE, RUN, HALTED}
  - PC increment constant 4
- Sub-module instruction_memory:
  - Single write port, async read, RAM_DEPTH x LEN.
  - Reusable for data-memory debug loading.
- Top keeps the FSM, PC, and IF/ID register.

Test Plan:
- Sequential fetch: load 0x20010005 @0, 0x20020003 @1, 0xFFFFFFFF @2; i_enable=1.
  - o_instruccion = 0x20010005 (adder_pc 4), then 0x20020003 (8), then 0xFFFFFFFF (12) with o_halt=1.
  - Then NOP, valid=0; PC remains 8.
- Stall: assert i_stall 2 cycles after first fetch -> o_pc=4 and o_instruccion=0x20010005 held 2 cycles, then resume at 0x20020003.
- Jump squash: i_jump=1, target 0x40 while at PC 4.
  - Without macro: next IF/ID = NOP, valid=0; PC=0x40, then mem[16] fetched.
  - With macro: mem[1] is delivered valid.
- Jump + branch together: jump 0x40, branch 0x80 -> PC=0x40.
- Load lockout and reset: i_load_we in RUN leaves mem unchanged.
  - Async i_rst=0 mid-run -> outputs zero, o_valid=0 without a clock edge.
  - Program survives; rerun reproduces the sequential fetch scenario.
- Wrap: jump to 0xFFFFFFFC -> fetch mem[RAM_DEPTH-1 index] with adder_pc 0; next PC=0.
